// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared constants and state encoding for the boot image loader
package uart_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         CSUM_W            = 8;

    // One-hot, same style as the UART receiver FSM
    typedef enum logic [5:0] {
        ST_SYNC   = 6'b000001,
        ST_LEN_LO = 6'b000010,
        ST_LEN_HI = 6'b000100,
        ST_DATA   = 6'b001000,
        ST_CSUM   = 6'b010000,
        ST_RUN    = 6'b100000
    } state_e;

endpackage

// File: rtl/uart_loader_if.sv
// rtl/uart_loader_if.sv - receiver byte handshake and instruction-memory write port
interface uart_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  rx_valid_i;
    logic [7:0]            rx_data_i;
    logic                  rx_stb_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_wdata_o;

    modport loader (
        input  rx_valid_i,
        input  rx_data_i,
        output rx_stb_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o
    );

    modport host (
        output rx_valid_i,
        output rx_data_i,
        input  rx_stb_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o
    );
endinterface

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - framed UART boot image loader writing instruction memory
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_loader_if.loader bus,
    output logic          cpu_rst_o,
    output logic          done_o,
    output logic          err_o
);

    state_e                state_q, state_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [CSUM_W-1:0]     csum_q, csum_d;
    logic [23:0]           word_q, word_d;
    logic [1:0]            idx_q, idx_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic       accept;
    logic [7:0] rx_byte;

    // The receiver still shows the consumed byte while the strobe is high
    assign accept  = bus.rx_valid_i & ~stb_q;
    assign rx_byte = bus.rx_data_i;

    always_comb begin
        state_d   = state_q;
        stb_d     = accept;
        we_d      = 1'b0;
        addr_d    = addr_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        word_d    = word_q;
        idx_d     = idx_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;
        if (accept) begin
            case (state_q)
                ST_SYNC: begin
                    if (rx_byte == SYNC_BYTE) begin
                        err_d   = 1'b0;
                        csum_d  = '0;
                        waddr_d = '0;
                        idx_d   = 2'd0;
                        state_d = ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    cnt_d[7:0] = rx_byte;
                    state_d    = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    cnt_d[15:8] = rx_byte;
                    state_d     = ({rx_byte, cnt_q[7:0]} == 16'd0) ? ST_CSUM : ST_DATA;
                end
                ST_DATA: begin
                    // Only the three earlier bytes are stored; the 4th goes straight to wdata
                    word_d = {rx_byte, word_q[23:8]};
                    csum_d = csum_q ^ rx_byte;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = waddr_q;
                        wdata_d = {rx_byte, word_q};
                        waddr_d = waddr_q + ADDR_WIDTH'(1);
                        cnt_d   = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_byte == csum_q) begin
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                        state_d   = ST_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_SYNC;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_SYNC;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            word_q    <= '0;
            idx_q     <= 2'd0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.rx_stb_o    = stb_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign cpu_rst_o       = cpu_rst_q;
    assign done_o          = done_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - bench for uart_loader, 10-bit and 2-bit address instances in lockstep
module tb_uart_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       cpu0, done0, err0;
    logic       cpu1, done1, err1;

    uart_loader_if #(.ADDR_WIDTH(10)) bus0 ();
    uart_loader_if #(.ADDR_WIDTH(2))  bus1 ();

    assign bus0.rx_valid_i = rx_valid;
    assign bus0.rx_data_i  = rx_data;
    assign bus1.rx_valid_i = rx_valid;
    assign bus1.rx_data_i  = rx_data;

    uart_loader #(.ADDR_WIDTH(10), .SYNC_BYTE(8'hA5)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0),
        .cpu_rst_o(cpu0), .done_o(done0), .err_o(err0)
    );

    uart_loader #(.ADDR_WIDTH(2), .SYNC_BYTE(8'hA5)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1),
        .cpu_rst_o(cpu1), .done_o(done1), .err_o(err1)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          stb_cnt = 0;
    int          ga0[$];
    int          ga1[$];
    logic [31:0] gd0[$];
    logic [31:0] gd1[$];
    logic [31:0] wq[$];
    bit          done_m, err_m, cpu_rst_m;
    logic        last_done0, last_cpu0, last_err0;

    always @(negedge clk) begin
        if (bus0.mem_we_o) begin
            ga0.push_back(int'(bus0.mem_addr_o));
            gd0.push_back(bus0.mem_wdata_o);
        end
        if (bus1.mem_we_o) begin
            ga1.push_back(int'(bus1.mem_addr_o));
            gd1.push_back(bus1.mem_wdata_o);
        end
        if (bus0.rx_stb_o) stb_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_writes();
        ga0.delete(); gd0.delete(); ga1.delete(); gd1.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_ctl0", 32'({bus0.rx_stb_o, bus0.mem_we_o, cpu0, done0, err0}), 32'h4);
        chk("rst_ctl1", 32'({bus1.rx_stb_o, bus1.mem_we_o, cpu1, done1, err1}), 32'h4);
        chk("rst_addr0", 32'(bus0.mem_addr_o), 32'h0);
        chk("rst_wdata0", bus0.mem_wdata_o, 32'h0);
        done_m = 1'b0; err_m = 1'b0; cpu_rst_m = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Receiver model: valid held until the strobe, and still high during the strobe cycle
    task automatic send_byte(input logic [7:0] b);
        bit seen = 1'b0;
        int gap;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus0.rx_stb_o) seen = 1'b1;
        end
        chk("stb_seen", 32'(seen), 32'h1);
        last_done0 = done0; last_cpu0 = cpu0; last_err0 = err0;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] mask, input int garbage_n);
        int          n = wq.size();
        int          exp_n;
        bit          was_done = done_m;
        logic [7:0]  cs = 8'h00;
        logic [7:0]  b;
        logic [31:0] w;
        clear_writes();
        for (int g = 0; g < garbage_n; g++) begin
            do b = 8'($urandom); while (!was_done && b == 8'hA5);
            send_byte(b);
        end
        send_byte(8'hA5);
        if (!was_done) err_m = 1'b0;
        chk("err_after_sync", 32'(err0), 32'(err_m));
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            w = wq[i];
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                cs = cs ^ b;
                send_byte(b);
            end
        end
        send_byte(cs ^ mask);
        if (!was_done) begin
            if (mask == 8'h00) begin
                done_m = 1'b1; cpu_rst_m = 1'b0;
            end else begin
                err_m = 1'b1;
            end
        end
        chk("done_at_last_stb", 32'(last_done0), 32'(done_m));
        chk("cpu_rst_at_last_stb", 32'(last_cpu0), 32'(cpu_rst_m));
        chk("err_at_last_stb", 32'(last_err0), 32'(err_m));
        repeat (3) begin @(posedge clk); #1; end
        exp_n = was_done ? 0 : n;
        chk("wr_count0", 32'(ga0.size()), 32'(exp_n));
        chk("wr_count1", 32'(ga1.size()), 32'(exp_n));
        for (int i = 0; i < exp_n && i < ga0.size() && i < ga1.size(); i++) begin
            chk("wr_addr0", 32'(ga0[i]), 32'(i % 1024));
            chk("wr_data0", gd0[i], wq[i]);
            chk("wr_addr1", 32'(ga1[i]), 32'(i % 4));
            chk("wr_data1", gd1[i], wq[i]);
        end
        if (exp_n > 0) chk("addr_hold0", 32'(bus0.mem_addr_o), 32'((exp_n - 1) % 1024));
        chk("status0", 32'({done0, err0, cpu0}), 32'({done_m, err_m, cpu_rst_m}));
        chk("status1", 32'({done1, err1, cpu1}), 32'({done_m, err_m, cpu_rst_m}));
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        do_reset();

        wq.delete(); wq.push_back(32'h44332211); wq.push_back(32'h88776655);
        send_frame(8'h00, 0);
        fill_random(2);
        send_frame(8'h00, 2);

        do_reset();
        clear_writes();
        c = stb_cnt;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        chk("garbage_stb", 32'(stb_cnt - c), 32'd3);
        chk("garbage_no_write", 32'(ga0.size()), 32'd0);
        wq.delete(); wq.push_back(32'hEFBEADDE);
        send_frame(8'h00, 0);

        do_reset();
        wq.delete(); wq.push_back(32'h04030201);
        send_frame(8'h04, 0);
        fill_random(3);
        send_frame(8'h00, 1);

        do_reset();
        wq.delete();
        send_frame(8'h00, 0);
        do_reset();
        send_frame(8'h01, 0);

        do_reset();
        c = stb_cnt;
        send_byte(8'h00);
        repeat (8) begin @(posedge clk); #1; end
        chk("one_stb_per_byte", 32'(stb_cnt - c), 32'd1);

        clear_writes();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        do_reset();
        chk("midframe_no_write", 32'(ga0.size()), 32'd0);
        fill_random(2);
        send_frame(8'h00, 0);

        do_reset();
        fill_random(5);
        send_frame(8'h00, 0);

        for (int t = 0; t < 6; t++) begin
            do_reset();
            fill_random(int'($urandom_range(0, 6)));
            send_frame(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                       int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
